// File: rtl/gbp_index_queue_pkg.sv
// Shared types for the gshare index replay queue.
// The PC-to-fetch-block slicing lives here so the predictor and the queue use one definition.
package gbp_index_queue_pkg;

  localparam int unsigned VLEN            = 32;
  localparam bit          RVC             = 1'b1;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned GBP_INDEX_BITS  = 8;

  localparam int unsigned OFFSET    = RVC ? 1 : 2;
  localparam int unsigned BLK_SHIFT = OFFSET + $clog2(INSTR_PER_FETCH);
  localparam int unsigned BLK_BITS  = VLEN - BLK_SHIFT;
  localparam int unsigned NBR_BITS  = $clog2(INSTR_PER_FETCH) + 1;

  typedef logic [GBP_INDEX_BITS-1:0] gbp_index_t;
  typedef logic [BLK_BITS-1:0]       blk_addr_t;
  typedef logic [NBR_BITS-1:0]       nbr_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    gbp_index_t index;
    blk_addr_t  blk_addr;
    nbr_t       remaining;
  } gbp_iq_entry_t;

  function automatic blk_addr_t gbp_blk_addr(input logic [VLEN-1:0] pc);
    return blk_addr_t'(pc >> BLK_SHIFT);
  endfunction

endpackage

// File: rtl/gbp_index_queue.sv
// In-order queue of gshare indices captured at prediction time, replayed alongside
// resolved-branch updates so the predictor trains the entry it actually read.
module gbp_index_queue
  import gbp_index_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  gbp_index_t               push_index_i,
  input  logic [VLEN-1:0]          push_pc_i,
  input  nbr_t                     push_nbr_i,
  input  bht_update_t              resolve_i,
  output bht_update_t              bht_update_o,
  output gbp_index_t               update_index_o,
  output logic                     mismatch_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS:0] FULL = (PTR_BITS + 1)'(DEPTH);

  gbp_iq_entry_t         r_entry [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PTR_BITS-1:0]   r_wptr;
  logic [PTR_BITS-1:0]   r_rptr;
  logic [PTR_BITS:0]     r_count;
  bht_update_t           r_update;
  gbp_index_t            r_update_index;
  logic                  r_mismatch;

  gbp_iq_entry_t w_head;
  logic          w_nonempty;
  logic          w_act;
  logic          w_match;
  logic          w_last;
  logic          w_pop;
  logic          w_nbr_ok;
  logic          w_ready;
  logic          w_push;
  nbr_t          w_rem_dec;

  assign w_head     = r_entry[r_rptr];
  assign w_nonempty = (r_count != '0);
  assign w_act      = resolve_i.valid && !debug_mode_i && !flush_i;
  assign w_match    = w_nonempty && (w_head.blk_addr == gbp_blk_addr(resolve_i.pc));
  assign w_last     = (w_head.remaining == nbr_t'(1));
  // A mismatching resolve means the head block is stale; drop it rather than stall.
  assign w_pop      = w_act && w_nonempty && (!w_match || w_last);
  assign w_nbr_ok   = (push_nbr_i != '0) && (push_nbr_i <= nbr_t'(INSTR_PER_FETCH));
  assign w_ready    = (r_count < FULL) || w_pop;
  assign w_push     = push_valid_i && w_ready && w_nbr_ok && !flush_i;
  assign w_rem_dec  = (w_head.remaining == '0) ? '0 : w_head.remaining - nbr_t'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_valid        <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_update       <= '0;
      r_update_index <= '0;
      r_mismatch     <= 1'b0;
    end else if (flush_i) begin
      r_valid        <= '0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_update       <= '0;
      r_update_index <= '0;
      r_mismatch     <= 1'b0;
    end else begin
      r_update       <= (w_act && w_match) ? resolve_i : '0;
      r_update_index <= (w_act && w_match) ? w_head.index : '0;
      r_mismatch     <= w_act && !w_match;

      if (w_act && w_match && !w_last) r_entry[r_rptr].remaining <= w_rem_dec;

      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PTR_BITS'(1);
      end
      // Placed after the pop so a full-queue push+pop into the same slot leaves it valid.
      if (w_push) begin
        r_entry[r_wptr] <= '{index: push_index_i,
                             blk_addr: gbp_blk_addr(push_pc_i),
                             remaining: push_nbr_i};
        r_valid[r_wptr] <= 1'b1;
        r_wptr          <= r_wptr + PTR_BITS'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_BITS + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign push_ready_o   = w_ready;
  assign bht_update_o   = r_update;
  assign update_index_o = r_update_index;
  assign mismatch_o     = r_mismatch;
  assign count_o        = r_count;

  a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_valid_i |-> push_ready_o);
  a_push_nbr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_valid_i && !flush_i) |-> w_nbr_ok);
  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= FULL);
  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_pop |-> (w_nonempty && r_valid[r_rptr]));

endmodule
